// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the router datapath: flit layout, direction codes,
// flit type codes and the switch-allocator state encoding.
// -----------------------------------------------------------------------------
package noc_pkg;

    // Flit layout: src [39:36], dst [35:32], timestamp [31:24], data [23:2], type [1:0]
    localparam int DATASIZE = 40;
    localparam int SRC_MSB  = 39;
    localparam int SRC_LSB  = 36;
    localparam int DST_MSB  = 35;
    localparam int DST_LSB  = 32;
    localparam int TS_MSB   = 31;
    localparam int TS_LSB   = 24;
    localparam int TYPE_MSB = 1;
    localparam int TYPE_LSB = 0;

    // Direction codes produced by route computation
    localparam logic [3:0] DIR_L    = 4'b0000;
    localparam logic [3:0] DIR_W    = 4'b0001;
    localparam logic [3:0] DIR_E    = 4'b0010;
    localparam logic [3:0] DIR_N    = 4'b0100;
    localparam logic [3:0] DIR_S    = 4'b1000;
    localparam logic [3:0] DIR_NONE = 4'b1111;

    typedef enum logic [1:0] {
        TYPE_SINGLE = 2'b00,
        TYPE_HEAD   = 2'b01,
        TYPE_BODY   = 2'b10,
        TYPE_TAIL   = 2'b11
    } flit_type_e;

    typedef enum logic {
        SA_IDLE   = 1'b0,
        SA_LOCKED = 1'b1
    } sa_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational rotating-priority arbiter. The requester just after rr_ptr
// has highest priority; the search wraps modulo N.
//
// Ports:
//   req    [N-1:0]  request vector
//   rr_ptr [IW-1:0] index of the last winner (lowest priority next time)
//   grant  [N-1:0]  one-hot grant, all zero when no request
//   winner [IW-1:0] index of the granted requester (0 when none)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N  = 5,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] winner
);

    logic found;

    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default before any branch, so no path leaves a value held (no latch).
    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        // First pass: indices above the pointer.
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i > int'(rr_ptr))) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                winner   = IW'(i);
            end
        end
        // Second pass: wrap around to indices at or below the pointer.
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i <= int'(rr_ptr))) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                winner   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/sa_port_arbiter.sv
// -----------------------------------------------------------------------------
// sa_port_arbiter
// Switch allocator for one router output port. Picks one route-computation
// stage round-robin, forwards its flit into a one-entry output register and
// keeps the port locked to that input from head flit to tail flit.
//
// Ports:
//   sa_clk     clock
//   rst        synchronous active-high reset
//   valid_in   [NUM_IN]           flit present at input i
//   dir_in     [4*NUM_IN]         direction code of input i, slice [4i+3:4i]
//   data_in    [DATASIZE*NUM_IN]  flit of input i
//   out_ready  downstream FIFO accepts a flit this cycle
//   grant_out  [NUM_IN]  one-hot, combinational: input i consumed at this edge
//   data_out   [DATASIZE] registered flit toward downstream
//   valid_out  data_out holds a valid flit
//   lock_busy  registered: port locked to one input
//   proto_err  sticky protocol-error flag
// -----------------------------------------------------------------------------
module sa_port_arbiter
    import noc_pkg::*;
#(
    parameter int         NUM_IN   = 5,
    parameter int         DATASIZE = noc_pkg::DATASIZE,
    parameter logic [3:0] PORT_DIR = 4'b0010
) (
    input  logic                       sa_clk,
    input  logic                       rst,
    input  logic [NUM_IN-1:0]          valid_in,
    input  logic [4*NUM_IN-1:0]        dir_in,
    input  logic [DATASIZE*NUM_IN-1:0] data_in,
    input  logic                       out_ready,
    output logic [NUM_IN-1:0]          grant_out,
    output logic [DATASIZE-1:0]        data_out,
    output logic                       valid_out,
    output logic                       lock_busy,
    output logic                       proto_err
);

    localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    sa_state_e             state, state_nxt;
    logic [IW-1:0]         rr_ptr, rr_ptr_nxt;
    logic [IW-1:0]         lock_idx, lock_idx_nxt;
    logic [IW-1:0]         arb_winner, sel_idx;
    logic [NUM_IN-1:0]     req, arb_grant;
    logic                  load_en, load, err_set;
    logic [DATASIZE-1:0]   sel_flit;
    flit_type_e            sel_type;

    logic [3:0]            dir  [NUM_IN];
    logic [DATASIZE-1:0]   flit [NUM_IN];

    for (genvar g = 0; g < NUM_IN; g++) begin : g_unpack
        assign dir[g]  = dir_in[4*g +: 4];
        assign flit[g] = data_in[DATASIZE*g +: DATASIZE];
    end

    // A "no route" code never requests, even if PORT_DIR were set to it.
    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            req[i] = valid_in[i] && (dir[i] == PORT_DIR) && (dir[i] != DIR_NONE);
        end
    end

    rr_arbiter #(.N(NUM_IN)) u_rr_arbiter (
        .req    (req),
        .rr_ptr (rr_ptr),
        .grant  (arb_grant),
        .winner (arb_winner)
    );

    // Output register is free when empty or being drained this cycle.
    assign load_en = !valid_out || out_ready;

    // Grant and source selection. While locked, dir_in is ignored and only
    // the owning input is considered.
    always_comb begin
        grant_out = '0;
        sel_idx   = lock_idx;
        case (state)
            SA_IDLE: begin
                sel_idx = arb_winner;
                if (load_en) grant_out = arb_grant;
            end
            SA_LOCKED: begin
                grant_out[lock_idx] = valid_in[lock_idx] && load_en;
            end
            default: ;
        endcase
    end

    assign load     = |grant_out;
    assign sel_flit = flit[sel_idx];
    assign sel_type = flit_type_e'(sel_flit[TYPE_MSB:TYPE_LSB]);

    // Next state. A flit is always forwarded once granted; bad type
    // sequences only raise proto_err.
    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        lock_idx_nxt = lock_idx;
        err_set      = 1'b0;
        if (load) begin
            case (state)
                SA_IDLE: begin
                    rr_ptr_nxt = sel_idx;
                    case (sel_type)
                        TYPE_HEAD: begin
                            state_nxt    = SA_LOCKED;
                            lock_idx_nxt = sel_idx;
                        end
                        TYPE_BODY: err_set = 1'b1;
                        default:   ;
                    endcase
                end
                SA_LOCKED: begin
                    case (sel_type)
                        TYPE_TAIL:   state_nxt = SA_IDLE;
                        TYPE_SINGLE: begin
                            err_set   = 1'b1;
                            state_nxt = SA_IDLE;
                        end
                        TYPE_HEAD:   err_set = 1'b1;
                        default:     ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking '<=' so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge sa_clk) begin
        if (rst) begin
            state     <= SA_IDLE;
            rr_ptr    <= IW'(NUM_IN - 1);
            lock_idx  <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            lock_busy <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            lock_idx  <= lock_idx_nxt;
            lock_busy <= (state_nxt == SA_LOCKED);
            proto_err <= proto_err | err_set;
            if (load) begin
                data_out  <= sel_flit;
                valid_out <= 1'b1;
            end else if (out_ready) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sa_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sa_port_arbiter
// Directed vector table plus randomized traffic for sa_port_arbiter (E port).
// A packet-level reference model predicts grants and register contents.
// -----------------------------------------------------------------------------
module tb_sa_port_arbiter;
    import noc_pkg::*;

    localparam int         N  = 5;
    localparam int         DW = 40;
    localparam logic [3:0] PD = 4'b0010;

    logic              sa_clk = 1'b0;
    logic              rst;
    logic [N-1:0]      valid_in;
    logic [4*N-1:0]    dir_in;
    logic [DW*N-1:0]   data_in;
    logic              out_ready;
    logic [N-1:0]      grant_out;
    logic [DW-1:0]     data_out;
    logic              valid_out;
    logic              lock_busy;
    logic              proto_err;

    always #5 sa_clk = ~sa_clk;

    sa_port_arbiter #(.NUM_IN(N), .DATASIZE(DW), .PORT_DIR(PD)) dut (
        .sa_clk    (sa_clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .dir_in    (dir_in),
        .data_in   (data_in),
        .out_ready (out_ready),
        .grant_out (grant_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .lock_busy (lock_busy),
        .proto_err (proto_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (packet-level view) ----------------
    bit          m_vout;
    logic [DW-1:0] m_data;
    bit          m_lock;
    int          m_owner;
    int          m_last;
    bit          m_err;

    function automatic logic [N-1:0] model_grant();
        logic [N-1:0] g = '0;
        if (m_vout && !out_ready) return g;
        if (m_lock) begin
            g[m_owner] = valid_in[m_owner];
            return g;
        end
        for (int k = 1; k <= N; k++) begin
            int i = (m_last + k) % N;
            if (valid_in[i] && dir_in[4*i +: 4] == PD) begin
                g[i] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic model_update(input logic [N-1:0] g);
        int w = -1;
        logic [1:0] t;
        if (rst) begin
            m_vout = 0; m_data = '0; m_lock = 0; m_owner = 0; m_last = N - 1; m_err = 0;
            return;
        end
        for (int i = 0; i < N; i++) if (g[i]) w = i;
        if (w >= 0) begin
            m_data = data_in[DW*w +: DW];
            m_vout = 1;
            t = m_data[1:0];
            if (!m_lock) begin
                m_last = w;
                if (t == 2'b01) begin m_lock = 1; m_owner = w; end
                else if (t == 2'b10) m_err = 1;
            end else begin
                if (t == 2'b11) m_lock = 0;
                else if (t == 2'b00) begin m_err = 1; m_lock = 0; end
                else if (t == 2'b01) m_err = 1;
            end
        end else if (out_ready) begin
            m_vout = 0;
        end
    endtask

    // One clock: called just after a negedge with inputs applied.
    task automatic run_cycle(input string tag, output logic [N-1:0] g_seen);
        logic [N-1:0] g_exp;
        #1;
        g_exp  = model_grant();
        g_seen = grant_out;
        if (!rst) check({tag, " grant"}, 64'(grant_out), 64'(g_exp));
        @(posedge sa_clk);
        #1;
        model_update(g_exp);
        check({tag, " valid_out"}, 64'(valid_out), 64'(m_vout));
        check({tag, " data_out"},  64'(data_out),  64'(m_data));
        check({tag, " lock_busy"}, 64'(lock_busy), 64'(m_lock));
        check({tag, " proto_err"}, 64'(proto_err), 64'(m_err));
        @(negedge sa_clk);
    endtask

    // ---------------- directed stimulus ----------------
    function automatic logic [DW-1:0] mk_flit(input int i, input logic [1:0] t);
        return {4'(i), DIR_E, 8'hA5, 22'(i * 13 + 1), t};
    endfunction

    task automatic drive(input logic r, input logic [4:0] v, input logic [19:0] d,
                         input logic [9:0] t, input logic o);
        rst       = r;
        valid_in  = v;
        dir_in    = d;
        out_ready = o;
        for (int i = 0; i < N; i++) data_in[DW*i +: DW] = mk_flit(i, t[2*i +: 2]);
    endtask

    typedef struct {
        logic       r;
        logic [4:0] v;
        logic [19:0] d;
        logic [9:0] t;
        logic       o;
        logic [4:0] eg;
        logic       ev;
        logic       el;
        logic       ee;
        int         es;
        logic [1:0] et;
    } vec_t;

    function automatic vec_t mkv(logic r, logic [4:0] v, logic [19:0] d, logic [9:0] t,
                                 logic o, logic [4:0] eg, logic ev, logic el, logic ee,
                                 int es, logic [1:0] et);
        vec_t x;
        x.r = r; x.v = v; x.d = d; x.t = t; x.o = o; x.eg = eg;
        x.ev = ev; x.el = el; x.ee = ee; x.es = es; x.et = et;
        return x;
    endfunction

    localparam logic [19:0] DE = 20'h22222;

    vec_t tbl[$];

    initial begin
        logic [N-1:0] g;
        logic [3:0]   dir_pick [8];

        // Reset and check reset values.
        drive(1'b1, '0, DE, '0, 1'b1);
        run_cycle("reset0", g);
        drive(1'b0, '0, DE, '0, 1'b1);
        run_cycle("reset1", g);
        check("reset data_out zero", 64'(data_out), 64'd0);
        check("reset valid_out zero", 64'(valid_out), 64'd0);

        // Two single flits on inputs 1 and 3, then drain.
        tbl.push_back(mkv(0, 5'b01010, DE, 10'h000, 1, 5'b00010, 1, 0, 0, 1, 2'b00));
        tbl.push_back(mkv(0, 5'b01000, DE, 10'h000, 1, 5'b01000, 1, 0, 0, 3, 2'b00));
        tbl.push_back(mkv(0, 5'b00000, DE, 10'h000, 1, 5'b00000, 0, 0, 0, 0, 2'b00));
        // Round-robin across 0, 2, 4 from a fresh pointer.
        tbl.push_back(mkv(1, 5'b00000, DE, 10'h000, 1, 5'b00000, 0, 0, 0, 0, 2'b00));
        tbl.push_back(mkv(0, 5'b10101, DE, 10'h000, 1, 5'b00001, 1, 0, 0, 0, 2'b00));
        tbl.push_back(mkv(0, 5'b10101, DE, 10'h000, 1, 5'b00100, 1, 0, 0, 2, 2'b00));
        tbl.push_back(mkv(0, 5'b10101, DE, 10'h000, 1, 5'b10000, 1, 0, 0, 4, 2'b00));
        tbl.push_back(mkv(0, 5'b10101, DE, 10'h000, 1, 5'b00001, 1, 0, 0, 0, 2'b00));
        tbl.push_back(mkv(0, 5'b10101, DE, 10'h000, 1, 5'b00100, 1, 0, 0, 2, 2'b00));
        // Packet lock on input 2 while input 0 keeps requesting.
        tbl.push_back(mkv(1, 5'b00000, DE, 10'h000, 1, 5'b00000, 0, 0, 0, 0, 2'b00));
        tbl.push_back(mkv(0, 5'b00100, DE, 10'h010, 1, 5'b00100, 1, 1, 0, 2, 2'b01));
        tbl.push_back(mkv(0, 5'b00101, DE, 10'h020, 1, 5'b00100, 1, 1, 0, 2, 2'b10));
        tbl.push_back(mkv(0, 5'b00101, DE, 10'h020, 1, 5'b00100, 1, 1, 0, 2, 2'b10));
        tbl.push_back(mkv(0, 5'b00101, DE, 10'h030, 1, 5'b00100, 1, 0, 0, 2, 2'b11));
        tbl.push_back(mkv(0, 5'b00001, DE, 10'h000, 1, 5'b00001, 1, 0, 0, 0, 2'b00));
        // Back-pressure for 3 cycles, then drain and load together.
        tbl.push_back(mkv(0, 5'b00010, DE, 10'h000, 0, 5'b00000, 1, 0, 0, 0, 2'b00));
        tbl.push_back(mkv(0, 5'b00010, DE, 10'h000, 0, 5'b00000, 1, 0, 0, 0, 2'b00));
        tbl.push_back(mkv(0, 5'b00010, DE, 10'h000, 0, 5'b00000, 1, 0, 0, 0, 2'b00));
        tbl.push_back(mkv(0, 5'b00010, DE, 10'h000, 1, 5'b00010, 1, 0, 0, 1, 2'b00));
        tbl.push_back(mkv(0, 5'b00000, DE, 10'h000, 1, 5'b00000, 0, 0, 0, 0, 2'b00));
        // Body flit while idle, then no-route inputs.
        tbl.push_back(mkv(0, 5'b00100, DE, 10'h020, 1, 5'b00100, 1, 0, 1, 2, 2'b10));
        tbl.push_back(mkv(0, 5'b00100, 20'h22F22, 10'h000, 1, 5'b00000, 0, 0, 1, 0, 2'b00));
        tbl.push_back(mkv(0, 5'b11111, 20'hFFFFF, 10'h000, 1, 5'b00000, 0, 0, 1, 0, 2'b00));
        // Reset in the middle of a locked packet on input 3.
        tbl.push_back(mkv(0, 5'b01000, DE, 10'h040, 1, 5'b01000, 1, 1, 1, 3, 2'b01));
        tbl.push_back(mkv(0, 5'b01000, DE, 10'h080, 1, 5'b01000, 1, 1, 1, 3, 2'b10));
        tbl.push_back(mkv(1, 5'b01000, DE, 10'h080, 1, 5'b00000, 0, 0, 0, 0, 2'b00));
        tbl.push_back(mkv(0, 5'b11111, DE, 10'h000, 1, 5'b00001, 1, 0, 0, 0, 2'b00));

        foreach (tbl[i]) begin
            string tag;
            tag = $sformatf("row%0d", i);
            drive(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].t, tbl[i].o);
            run_cycle(tag, g);
            if (!tbl[i].r) check({tag, " tbl grant"}, 64'(g), 64'(tbl[i].eg));
            check({tag, " tbl valid_out"}, 64'(valid_out), 64'(tbl[i].ev));
            check({tag, " tbl lock_busy"}, 64'(lock_busy), 64'(tbl[i].el));
            check({tag, " tbl proto_err"}, 64'(proto_err), 64'(tbl[i].ee));
            if (tbl[i].ev)
                check({tag, " tbl data_out"}, 64'(data_out), 64'(mk_flit(tbl[i].es, tbl[i].et)));
        end

        // Randomized traffic against the model.
        dir_pick = '{DIR_L, DIR_W, DIR_E, DIR_N, DIR_S, DIR_NONE, DIR_E, DIR_E};
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            valid_in  = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                dir_in[4*i +: 4]   = dir_pick[$urandom_range(0, 7)];
                data_in[DW*i +: DW] = {8'($urandom), $urandom};
            end
            run_cycle($sformatf("rand%0d", c), g);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
